hangman_round_ctrl: RTL and testbench
=====================================

# hangman_round_ctrl

Round sequencer for the HangMaze game. Launches a round by pulsing the maze letter block's init, consumes its collected-letter/guess pulses, and scores each guess against the secret word over one character per clock. It maintains the revealed-position mask, used-letter set and lives counter, and declares win or loss. Sits between the top-level game FSM/keyboard word entry and the maze letter datapath; its outputs drive the word display and HUD.

## Interface
- WORD_LEN, 8: maximum secret word length in characters.
- MAX_LIVES, 6: lives granted at round start (1..15).
- Clk  in  1  system clock; all state on rising edge.
- Reset  in  1  asynchronous, active-low; clears all state.
- start  in  1  one-cycle pulse; begins a round from IDLE, WON or LOST.
- word  in  8*WORD_LEN  secret word, ASCII uppercase; char i at bits [8i+7:8i]; sampled at start.
- word_len  in  4  valid characters in word; sampled at start.
- check_guess  in  1  level from maze letter block; high while a fresh pickup is being reported.
- collected_letter  in  8  letter from maze letter block.
- init  out  1  init pulse to maze letter block.
- ilc  out  8  initial collected letter, constant 8'h20.
- revealed  out  WORD_LEN  bit i set = char i guessed.
- lives  out  4  remaining lives.
- busy  out  1  high in INIT, CHECK, UPDATE.
- won, lost  out  1  each high while in WON or LOST, respectively.

## Operation
- States: IDLE, INIT, PLAY, CHECK, UPDATE, WON, LOST.
- IDLE/WON/LOST + start:
  - If 1 <= word_len <= WORD_LEN: latch word and word_len, set lives = MAX_LIVES, clear revealed and used-letter set, go to INIT.
  - Otherwise ignore start and stay in the current state.
- INIT: assert init for exactly 2 cycles, then go to PLAY.
- PLAY: detect a guess on the rising edge of check_guess, i.e. registered prev = 0 and current = 1.
  - Capture collected_letter in that cycle.
  - Letter outside 8'h41..8'h5A: drop it and stay in PLAY.
  - Letter already in the used set: drop it with no life lost and stay in PLAY.
  - Otherwise mark the letter used, clear the hit flag, set index = 0, go to CHECK.
- CHECK: each cycle compare word char[index] with the guess.
  - On equal, set revealed[index] and the hit flag.
  - When index = word_len-1, go to UPDATE; otherwise increment index.
- UPDATE, evaluated in order:
  - All revealed[i] set for i < word_len: go to WON.
  - Else if hit = 0: lives -= 1; if the new value is 0, go to LOST, else go to PLAY.
  - Else go to PLAY.
- Rising edges of check_guess outside PLAY are discarded, not queued; the edge detector keeps running in every state.
- revealed bits at i >= word_len stay 0.
- lives saturates at 0 and never wraps.
- WON/LOST hold all outputs until start or Reset.

## Timing
- Reset values: state IDLE, init 0, ilc 8'h20, revealed 0, lives 0, busy 0, won 0, lost 0, edge register 0.
- Cycle after start is accepted: state INIT, init = 1 for that cycle and the next; PLAY on the third cycle.
- Guess latency: edge detected in cycle T; CHECK occupies T+1..T+word_len; UPDATE at T+word_len+1.
- revealed and lives reflect the guess at T+word_len+2, as do won/lost.
- revealed bits update during CHECK, one per cycle.
- start during INIT/PLAY/CHECK/UPDATE is ignored.
- Reset asserted mid-round: immediate return to reset values. init deasserts asynchronously.
- Simultaneous start and check_guess edge in WON/LOST: start wins and the guess is dropped.

## Test plan
- Reset mid-CHECK -> all outputs return to reset values immediately; next start with word_len 4 -> init high 2 cycles, lives = MAX_LIVES.
- Word "CAT", word_len 3, guess 'A' (8'h41) -> after 5 cycles revealed = 3'b010, lives 6; then 'C', 'T' -> won = 1, busy = 0.
- Word "DOG", guesses 'X','Y','Z','Q','V','W' -> lives 5,4,3,2,1,0; lost = 1 after 'W'; further guesses leave lives 0.
- Word "BOOK", guess 'O' -> revealed = 4'b0110; repeat 'O' -> no CHECK entry, lives unchanged; guess 8'h31 -> ignored.
- start with word_len 0 and with word_len 9 (WORD_LEN 8) -> state stays IDLE, init never asserts.
- check_guess held high 20 cycles in PLAY -> exactly one guess scored; edge during CHECK -> dropped.

Source files
------------

// File: rtl/hangman_round_ctrl.sv
// hangman_round_ctrl: round sequencer for HangMaze. Starts a round, pulses
// the maze letter block init, scores each fresh guess against the secret word
// one character per clock, and tracks revealed mask, used letters and lives.
module hangman_round_ctrl #(
  parameter int WORD_LEN  = 8,
  parameter int MAX_LIVES = 6
) (
  input  logic                  Clk,
  input  logic                  Reset,
  input  logic                  start,
  input  logic [8*WORD_LEN-1:0] word,
  input  logic [3:0]            word_len,
  input  logic                  check_guess,
  input  logic [7:0]            collected_letter,
  output logic                  init,
  output logic [7:0]            ilc,
  output logic [WORD_LEN-1:0]   revealed,
  output logic [3:0]            lives,
  output logic                  busy,
  output logic                  won,
  output logic                  lost
);

  localparam logic [7:0] ILC_CHAR   = 8'h20;
  localparam logic [3:0] LIVES_INIT = 4'(MAX_LIVES);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_INIT   = 3'd1,
    ST_PLAY   = 3'd2,
    ST_CHECK  = 3'd3,
    ST_UPDATE = 3'd4,
    ST_WON    = 3'd5,
    ST_LOST   = 3'd6
  } state_t;

  // Bit i set for every character position below len.
  function automatic logic [WORD_LEN-1:0] len_mask(input logic [3:0] len);
    logic [WORD_LEN-1:0] m;
    m = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      m[i] = (i < int'(len));
    end
    return m;
  endfunction

  state_t                state_r;
  logic [8*WORD_LEN-1:0] word_r;
  logic [3:0]            len_r;
  logic [3:0]            idx_r;
  logic [7:0]            guess_r;
  logic                  hit_r;
  logic [25:0]           used_r;
  logic                  prev_r;
  logic                  init_r;
  logic                  init_cnt_r;
  logic [7:0]            ilc_r;
  logic [WORD_LEN-1:0]   revealed_r;
  logic [3:0]            lives_r;
  logic                  busy_r;
  logic                  won_r;
  logic                  lost_r;

  logic                  edge_s;
  logic                  start_ok_s;
  logic                  letter_ok_s;
  logic [4:0]            letter_idx_s;
  logic                  letter_used_s;
  logic [WORD_LEN-1:0]   len_mask_s;
  logic                  all_rev_s;
  logic [7:0]            cur_char_s;
  logic [WORD_LEN-1:0]   idx_onehot_s;
  logic                  char_hit_s;
  logic                  last_idx_s;
  logic [3:0]            lives_dec_s;

  assign edge_s        = check_guess & ~prev_r;
  assign start_ok_s    = start && (word_len >= 4'd1) && (int'(word_len) <= WORD_LEN);
  assign letter_ok_s   = (collected_letter >= 8'h41) && (collected_letter <= 8'h5A);
  assign letter_idx_s  = 5'(collected_letter - 8'h41);
  assign letter_used_s = used_r[letter_idx_s];
  assign len_mask_s    = len_mask(len_r);
  assign all_rev_s     = ((revealed_r & len_mask_s) == len_mask_s);
  assign char_hit_s    = (cur_char_s == guess_r);
  assign last_idx_s    = (idx_r == (len_r - 4'd1));
  assign lives_dec_s   = (lives_r == 4'd0) ? 4'd0 : (lives_r - 4'd1);

  // Select the word character at the scan index as an AND-OR mux.
  always_comb begin
    cur_char_s   = 8'h00;
    idx_onehot_s = '0;
    for (int i = 0; i < WORD_LEN; i++) begin
      idx_onehot_s[i] = (idx_r == 4'(i));
      cur_char_s      = cur_char_s | (idx_onehot_s[i] ? word_r[8*i +: 8] : 8'h00);
    end
  end

  // Round state machine with registered outputs and guess edge detector.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_r    <= ST_IDLE;
      word_r     <= '0;
      len_r      <= 4'd0;
      idx_r      <= 4'd0;
      guess_r    <= 8'h00;
      hit_r      <= 1'b0;
      used_r     <= 26'd0;
      prev_r     <= 1'b0;
      init_r     <= 1'b0;
      init_cnt_r <= 1'b0;
      ilc_r      <= ILC_CHAR;
      revealed_r <= '0;
      lives_r    <= 4'd0;
      busy_r     <= 1'b0;
      won_r      <= 1'b0;
      lost_r     <= 1'b0;
    end else begin
      prev_r <= check_guess;
      ilc_r  <= ILC_CHAR;
      case (state_r)
        ST_IDLE, ST_WON, ST_LOST: begin
          // start has priority over any guess edge in the same cycle
          if (start_ok_s) begin
            word_r     <= word;
            len_r      <= word_len;
            lives_r    <= LIVES_INIT;
            revealed_r <= '0;
            used_r     <= 26'd0;
            init_r     <= 1'b1;
            init_cnt_r <= 1'b0;
            busy_r     <= 1'b1;
            won_r      <= 1'b0;
            lost_r     <= 1'b0;
            state_r    <= ST_INIT;
          end
        end
        ST_INIT: begin
          if (init_cnt_r == 1'b0) begin
            init_cnt_r <= 1'b1;
          end else begin
            init_r  <= 1'b0;
            busy_r  <= 1'b0;
            state_r <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          // invalid or repeated letters are dropped without leaving PLAY
          if (edge_s && letter_ok_s && !letter_used_s) begin
            used_r[letter_idx_s] <= 1'b1;
            guess_r <= collected_letter;
            hit_r   <= 1'b0;
            idx_r   <= 4'd0;
            busy_r  <= 1'b1;
            state_r <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (char_hit_s) begin
            revealed_r <= revealed_r | (idx_onehot_s & len_mask_s);
            hit_r      <= 1'b1;
          end
          if (last_idx_s) begin
            state_r <= ST_UPDATE;
          end else begin
            idx_r <= idx_r + 4'd1;
          end
        end
        ST_UPDATE: begin
          busy_r <= 1'b0;
          if (all_rev_s) begin
            won_r   <= 1'b1;
            state_r <= ST_WON;
          end else if (!hit_r) begin
            lives_r <= lives_dec_s;
            if (lives_dec_s == 4'd0) begin
              lost_r  <= 1'b1;
              state_r <= ST_LOST;
            end else begin
              state_r <= ST_PLAY;
            end
          end else begin
            state_r <= ST_PLAY;
          end
        end
        default: begin
          init_r  <= 1'b0;
          busy_r  <= 1'b0;
          won_r   <= 1'b0;
          lost_r  <= 1'b0;
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

  assign init     = init_r;
  assign ilc      = ilc_r;
  assign revealed = revealed_r;
  assign lives    = lives_r;
  assign busy     = busy_r;
  assign won      = won_r;
  assign lost     = lost_r;

endmodule

// File: tb/tb_hangman_round_ctrl.sv
// Self-checking bench for hangman_round_ctrl: table of guesses per round plus
// hand-written sequences for reset, invalid start, held and overlapping edges.
module tb_hangman_round_ctrl;

  localparam int WL = 8;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          start;
  logic [8*WL-1:0] word;
  logic [3:0]    word_len;
  logic          check_guess;
  logic [7:0]    collected_letter;
  logic          init;
  logic [7:0]    ilc;
  logic [WL-1:0] revealed;
  logic [3:0]    lives;
  logic          busy;
  logic          won;
  logic          lost;

  int n_pass = 0;
  int n_total = 0;

  localparam logic [63:0] W_CAT  = {40'h0, 8'h54, 8'h41, 8'h43};
  localparam logic [63:0] W_DOG  = {40'h0, 8'h47, 8'h4F, 8'h44};
  localparam logic [63:0] W_BOOK = {32'h0, 8'h4B, 8'h4F, 8'h4F, 8'h42};

  typedef struct {
    logic        new_round;
    logic [63:0] w;
    logic [3:0]  len;
    logic [7:0]  letter;
    logic [7:0]  exp_rev;
    logic [3:0]  exp_lives;
    logic        exp_won;
    logic        exp_lost;
  } vec_t;

  vec_t vec[16];
  logic [3:0] cur_len;

  hangman_round_ctrl #(.WORD_LEN(WL), .MAX_LIVES(6)) dut (
    .Clk(Clk), .Reset(Reset), .start(start), .word(word), .word_len(word_len),
    .check_guess(check_guess), .collected_letter(collected_letter),
    .init(init), .ilc(ilc), .revealed(revealed), .lives(lives),
    .busy(busy), .won(won), .lost(lost)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " init"}, 32'(init), 32'd0);
    chk({tag, " ilc"}, 32'(ilc), 32'h20);
    chk({tag, " revealed"}, 32'(revealed), 32'd0);
    chk({tag, " lives"}, 32'(lives), 32'd0);
    chk({tag, " busy"}, 32'(busy), 32'd0);
    chk({tag, " won"}, 32'(won), 32'd0);
    chk({tag, " lost"}, 32'(lost), 32'd0);
  endtask

  // Called at a negedge; leaves the DUT in PLAY at a negedge.
  task automatic start_round(input logic [63:0] w, input logic [3:0] l);
    word = w; word_len = l; start = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    chk("init cycle1", 32'(init), 32'd1);
    chk("busy in init", 32'(busy), 32'd1);
    @(negedge Clk);
    chk("init cycle2", 32'(init), 32'd1);
    @(negedge Clk);
    chk("init done", 32'(init), 32'd0);
    chk("start lives", 32'(lives), 32'd6);
    chk("start revealed", 32'(revealed), 32'd0);
    chk("start won/lost", 32'({won, lost}), 32'd0);
    cur_len = l;
  endtask

  // One-cycle check_guess pulse, then wait until the result is visible.
  task automatic guess(input logic [7:0] letter);
    check_guess = 1'b1; collected_letter = letter;
    @(negedge Clk);
    check_guess = 1'b0;
    repeat (int'(cur_len) + 1) @(negedge Clk);
  endtask

  initial begin
    Reset = 1'b0; start = 1'b0; word = '0; word_len = 4'd0;
    check_guess = 1'b0; collected_letter = 8'h00; cur_len = 4'd3;

    vec[0]  = '{1'b1, W_CAT,  4'd3, 8'h41, 8'h02, 4'd6, 1'b0, 1'b0};
    vec[1]  = '{1'b0, W_CAT,  4'd3, 8'h43, 8'h03, 4'd6, 1'b0, 1'b0};
    vec[2]  = '{1'b0, W_CAT,  4'd3, 8'h54, 8'h07, 4'd6, 1'b1, 1'b0};
    vec[3]  = '{1'b1, W_DOG,  4'd3, 8'h58, 8'h00, 4'd5, 1'b0, 1'b0};
    vec[4]  = '{1'b0, W_DOG,  4'd3, 8'h59, 8'h00, 4'd4, 1'b0, 1'b0};
    vec[5]  = '{1'b0, W_DOG,  4'd3, 8'h5A, 8'h00, 4'd3, 1'b0, 1'b0};
    vec[6]  = '{1'b0, W_DOG,  4'd3, 8'h51, 8'h00, 4'd2, 1'b0, 1'b0};
    vec[7]  = '{1'b0, W_DOG,  4'd3, 8'h56, 8'h00, 4'd1, 1'b0, 1'b0};
    vec[8]  = '{1'b0, W_DOG,  4'd3, 8'h57, 8'h00, 4'd0, 1'b0, 1'b1};
    vec[9]  = '{1'b0, W_DOG,  4'd3, 8'h4B, 8'h00, 4'd0, 1'b0, 1'b1};
    vec[10] = '{1'b1, W_BOOK, 4'd4, 8'h4F, 8'h06, 4'd6, 1'b0, 1'b0};
    vec[11] = '{1'b0, W_BOOK, 4'd4, 8'h4F, 8'h06, 4'd6, 1'b0, 1'b0};
    vec[12] = '{1'b0, W_BOOK, 4'd4, 8'h31, 8'h06, 4'd6, 1'b0, 1'b0};
    vec[13] = '{1'b0, W_BOOK, 4'd4, 8'h5A, 8'h06, 4'd5, 1'b0, 1'b0};
    vec[14] = '{1'b0, W_BOOK, 4'd4, 8'h42, 8'h07, 4'd5, 1'b0, 1'b0};
    vec[15] = '{1'b0, W_BOOK, 4'd4, 8'h4B, 8'h0F, 4'd5, 1'b1, 1'b0};

    // Reset state
    @(negedge Clk);
    chk_reset_vals("reset");
    Reset = 1'b1;
    @(negedge Clk);

    // Out-of-range word_len is ignored in IDLE
    for (int k = 0; k < 2; k++) begin
      word = W_CAT; word_len = (k == 0) ? 4'd0 : 4'd9; start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      for (int c = 0; c < 3; c++) begin
        chk("bad len init", 32'(init), 32'd0);
        chk("bad len busy", 32'(busy), 32'd0);
        @(negedge Clk);
      end
      chk("bad len lives", 32'(lives), 32'd0);
    end

    // Table-driven rounds
    for (int i = 0; i < 16; i++) begin
      if (vec[i].new_round) start_round(vec[i].w, vec[i].len);
      guess(vec[i].letter);
      chk($sformatf("v%0d revealed", i), 32'(revealed), 32'(vec[i].exp_rev));
      chk($sformatf("v%0d lives", i), 32'(lives), 32'(vec[i].exp_lives));
      chk($sformatf("v%0d won", i), 32'(won), 32'(vec[i].exp_won));
      chk($sformatf("v%0d lost", i), 32'(lost), 32'(vec[i].exp_lost));
      chk($sformatf("v%0d busy", i), 32'(busy), 32'd0);
    end

    // Start and guess edge together in WON: start wins, guess dropped
    word = W_CAT; word_len = 4'd3; start = 1'b1;
    check_guess = 1'b1; collected_letter = 8'h41;
    @(negedge Clk);
    start = 1'b0; check_guess = 1'b0;
    chk("simul init", 32'(init), 32'd1);
    chk("simul won clr", 32'(won), 32'd0);
    repeat (7) @(negedge Clk);
    chk("simul revealed", 32'(revealed), 32'd0);
    chk("simul lives", 32'(lives), 32'd6);
    cur_len = 4'd3;

    // check_guess held high 20 cycles with a changing letter: one guess only
    check_guess = 1'b1; collected_letter = 8'h58;
    @(negedge Clk);
    collected_letter = 8'h59;
    repeat (19) @(negedge Clk);
    check_guess = 1'b0;
    repeat (3) @(negedge Clk);
    chk("held lives", 32'(lives), 32'd5);
    chk("held busy", 32'(busy), 32'd0);

    // Edge during CHECK is dropped, not queued
    check_guess = 1'b1; collected_letter = 8'h5A;
    @(negedge Clk);
    check_guess = 1'b0;
    @(negedge Clk);
    check_guess = 1'b1; collected_letter = 8'h41;
    @(negedge Clk);
    check_guess = 1'b0;
    repeat (2) @(negedge Clk);
    chk("chk-edge lives", 32'(lives), 32'd4);
    chk("chk-edge revealed", 32'(revealed), 32'd0);
    repeat (6) @(negedge Clk);
    chk("chk-edge not queued", 32'(revealed), 32'd0);

    // Repeated letter never enters CHECK
    check_guess = 1'b1; collected_letter = 8'h5A;
    @(negedge Clk);
    check_guess = 1'b0;
    chk("repeat no check", 32'(busy), 32'd0);
    repeat (4) @(negedge Clk);
    chk("repeat lives", 32'(lives), 32'd4);

    // Reset asserted mid-CHECK returns to reset values immediately
    check_guess = 1'b1; collected_letter = 8'h43;
    @(negedge Clk);
    check_guess = 1'b0;
    chk("mid check busy", 32'(busy), 32'd1);
    #2 Reset = 1'b0;
    #1 chk_reset_vals("async reset");
    @(negedge Clk);
    Reset = 1'b1;
    @(negedge Clk);
    start_round(W_BOOK, 4'd4);
    guess(8'h4B);
    chk("post reset revealed", 32'(revealed), 32'h08);
    chk("post reset lives", 32'(lives), 32'd6);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
